// File: rtl/checker_engine.sv
// checker_engine: execution stage behind checker_ctlif.
// It runs one check per start request. The check is either a timed dummy run
// or a sequential 64-bit read sweep that builds an XOR checksum. The bus
// master has a single outstanding strobe/ack request.
// Optional build macro: CHECKER_TIMEOUT_EN adds an ack watchdog in REQ.
module checker_engine #(
  parameter int unsigned WORDS          = 16,
  parameter int unsigned DUMMY_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  cmode,
  input  logic        cstart,
  input  logic [63:0] caddr,
  output logic        cend,
  output logic [7:0]  cctrl,
  output logic [63:0] cresult,
  output logic [63:0] m_adr,
  output logic        m_stb,
  input  logic        m_ack,
  input  logic [63:0] m_dat_i
);

  typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_REQ, S_DONE, S_HOLD} state_t;

  // Completion flags, laid out to match cctrl[4:0].
  typedef struct packed {
    logic bad_mode;
    logic misaligned;
    logic timeout;
    logic abort;
    logic ok;
  } status_t;

  localparam logic [1:0] MODE_DUMMY = 2'd0;
  localparam logic [1:0] MODE_READ  = 2'd1;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [63:0] adr_q, adr_d;
  logic        stb_q, stb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  status_t     status_q, status_d;
  logic        cend_q, cend_d;
  logic [7:0]  cctrl_q, cctrl_d;
  logic [63:0] cresult_q, cresult_d;
  logic        abort_now;
`ifdef CHECKER_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
`endif

  // A stop request can come from the sticky flag or from the current cycle.
  assign abort_now = abort_q | ~cstart;

  // Next-state and datapath updates for every FSM state.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    state_d   = state_q;
    mode_d    = mode_q;
    adr_d     = adr_q;
    stb_d     = stb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    status_d  = status_q;
    cend_d    = 1'b0;
    cctrl_d   = cctrl_q;
    cresult_d = cresult_q;
`ifdef CHECKER_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cstart) begin
          mode_d    = cmode;
          adr_d     = caddr;
          acc_d     = '0;
          cnt_d     = '0;
          abort_d   = 1'b0;
          status_d  = '0;
          cctrl_d   = '0;
          cresult_d = '0;
`ifdef CHECKER_TIMEOUT_EN
          wd_d      = '0;
`endif
          if (cmode[1]) begin
            status_d.bad_mode = 1'b1;
            state_d           = S_DONE;
          end else if (cmode == MODE_READ && caddr[2:0] != 3'd0) begin
            status_d.misaligned = 1'b1;
            state_d             = S_DONE;
          end else if (cmode == MODE_DUMMY) begin
            state_d = S_DUMMY;
          end else begin
            stb_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_DUMMY: begin
        cnt_d = cnt_q + 32'd1;
        // An expiring count wins over a stop request in the same cycle.
        if (cnt_d == DUMMY_CYCLES) begin
          status_d.ok = 1'b1;
          state_d     = S_DONE;
        end else if (!cstart) begin
          status_d.abort = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_REQ: begin
        // The request is never retracted. A stop only takes effect at the next ack.
        if (!cstart) abort_d = 1'b1;
        if (m_ack) begin
          acc_d = acc_q ^ m_dat_i;
          adr_d = adr_q + 64'd8;
          cnt_d = cnt_q + 32'd1;
`ifdef CHECKER_TIMEOUT_EN
          wd_d  = '0;
`endif
          if (cnt_q == WORDS - 32'd1) begin
            status_d.ok = 1'b1;
            stb_d       = 1'b0;
            state_d     = S_DONE;
          end else if (abort_now) begin
            status_d.abort = 1'b1;
            stb_d          = 1'b0;
            state_d        = S_DONE;
          end
        end
`ifdef CHECKER_TIMEOUT_EN
        else if (wd_q + 32'd1 == TIMEOUT_CYCLES) begin
          status_d.timeout = 1'b1;
          stb_d            = 1'b0;
          state_d          = S_DONE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
`endif
      end
      S_DONE: begin
        cend_d    = 1'b1;
        cctrl_d   = {1'b0, mode_q, status_q};
        cresult_d = acc_q;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        // A start level left high must not restart the engine.
        if (!cstart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments, so every register updates from the
    // values it had before the edge.
    if (!sys_rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      adr_q     <= '0;
      stb_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      status_q  <= '0;
      cend_q    <= 1'b0;
      cctrl_q   <= '0;
      cresult_q <= '0;
`ifdef CHECKER_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      adr_q     <= adr_d;
      stb_q     <= stb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      status_q  <= status_d;
      cend_q    <= cend_d;
      cctrl_q   <= cctrl_d;
      cresult_q <= cresult_d;
`ifdef CHECKER_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign cend    = cend_q;
  assign cctrl   = cctrl_q;
  assign cresult = cresult_q;
  assign m_adr   = adr_q;
  assign m_stb   = stb_q;

endmodule

// File: tb/tb_checker_engine.sv
// tb_checker_engine: scoreboard bench for checker_engine.
// It runs with WORDS=4, DUMMY_CYCLES=8 and TIMEOUT_CYCLES=16.
// The timeout case is built only when CHECKER_TIMEOUT_EN is defined.
module tb_checker_engine;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  cmode;
  logic        cstart;
  logic [63:0] caddr;
  logic        cend;
  logic [7:0]  cctrl;
  logic [63:0] cresult;
  logic [63:0] m_adr;
  logic        m_stb;
  logic        m_ack;
  logic [63:0] m_dat_i;

  checker_engine #(
    .WORDS         (4),
    .DUMMY_CYCLES  (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cmode   (cmode),
    .cstart  (cstart),
    .caddr   (caddr),
    .cend    (cend),
    .cctrl   (cctrl),
    .cresult (cresult),
    .m_adr   (m_adr),
    .m_stb   (m_stb),
    .m_ack   (m_ack),
    .m_dat_i (m_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0]  ctrl;
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] adr_q[$];
  logic [63:0] rsp_q[$];
  logic [63:0] word_val[4];

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay = 0;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  int stb_cycles = 0;
  int ack_cnt = 0;

  // Count one comparison and report any mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: ack after ack_delay wait cycles and check each acked address.
  always @(negedge sys_clk) begin
    logic [63:0] exp_a;
    if (m_stb) stb_cycles++;
    if (m_stb && ack_en) begin
      if (wait_cnt == ack_delay) begin
        exp_a   = (adr_q.size() > 0) ? adr_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check("bus_adr", m_adr, exp_a);
        m_dat_i = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
        m_ack   = 1'b1;
        ack_cnt++;
        wait_cnt = 0;
      end else begin
        m_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      m_ack    = 1'b0;
      wait_cnt = 0;
    end
  end

  // Run one check. Push the expected completion, wait for cend (bounded),
  // then pop the expectation and compare.
  task automatic run(input string tag, input logic [1:0] mode, input logic [63:0] addr,
                     input int delay, input bit ack_on, input int drop_at,
                     input logic [7:0] exp_ctrl, input logic [63:0] exp_res,
                     input int exp_lat, input int exp_stb);
    exp_t e;
    int   n;
    bit   seen;
    adr_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) begin
      adr_q.push_back(addr + 64'(8 * i));
      rsp_q.push_back(word_val[i]);
    end
    ack_delay  = delay;
    ack_en     = ack_on;
    stb_cycles = 0;
    ack_cnt    = 0;
    cmode      = mode;
    caddr      = addr;
    cstart     = 1'b1;
    exp_q.push_back('{exp_ctrl, exp_res, exp_lat});
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
      if (n == drop_at) cstart = 1'b0;
      if (cend) seen = 1'b1;
    end
    if (!seen) check({tag, "_end"}, 64'(cend), 64'd1);
    e = exp_q.pop_front();
    check({tag, "_ctrl"}, 64'(cctrl), 64'(e.ctrl));
    check({tag, "_res"}, cresult, e.res);
    check({tag, "_lat"}, 64'(n - 1), 64'(e.lat));
    check({tag, "_stb"}, 64'(stb_cycles), 64'(exp_stb));
    @(negedge sys_clk);
    check({tag, "_cend1"}, 64'(cend), 64'd0);
    check({tag, "_hold"}, 64'(cctrl), 64'(e.ctrl));
    cstart = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int cend_cnt;
    sys_rst = 1'b0;
    cmode   = '0;
    cstart  = 1'b0;
    caddr   = '0;
    m_ack   = 1'b0;
    m_dat_i = '0;
    word_val[0] = 64'd1;
    word_val[1] = 64'd2;
    word_val[2] = 64'd4;
    word_val[3] = 64'd8;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_cend", 64'(cend), 64'd0);
    check("rst_cctrl", 64'(cctrl), 64'd0);
    check("rst_cresult", cresult, 64'd0);
    check("rst_stb", 64'(m_stb), 64'd0);
    check("rst_adr", m_adr, 64'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);

    run("dummy", 2'd0, 64'h1000, 0, 1'b1, 0, 8'h01, 64'd0, 9, 0);
    run("read", 2'd1, 64'h1000, 0, 1'b1, 0, 8'h21, 64'hF, 5, 4);

    word_val[0] = 64'h1234_5678_9ABC_DEF0;
    word_val[1] = 64'h0F0F_0F0F_0F0F_0F0F;
    word_val[2] = 64'hFFFF_0000_FFFF_0000;
    word_val[3] = 64'h8000_0000_0000_0001;
    run("abort", 2'd1, 64'h2000, 3, 1'b1, 6, 8'h22, word_val[0] ^ word_val[1], 9, 8);
    check("abort_acks", 64'(ack_cnt), 64'd2);

    run("misalign", 2'd1, 64'h1004, 0, 1'b1, 0, 8'h28, 64'd0, 1, 0);
    run("badmode", 2'd3, 64'h1000, 0, 1'b1, 0, 8'h70, 64'd0, 1, 0);
    run("wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b1, 0, 8'h21,
        word_val[0] ^ word_val[1] ^ word_val[2] ^ word_val[3], 5, 4);

    // Reset while a read is in progress.
    adr_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) begin
      adr_q.push_back(64'h4000 + 64'(8 * i));
      rsp_q.push_back(word_val[i]);
    end
    ack_delay = 3;
    ack_en    = 1'b1;
    cmode     = 2'd1;
    caddr     = 64'h4000;
    cstart    = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("mrst_pre_stb", 64'(m_stb), 64'd1);
    sys_rst = 1'b0;
    cstart  = 1'b0;
    @(negedge sys_clk);
    check("mrst_stb", 64'(m_stb), 64'd0);
    check("mrst_adr", m_adr, 64'd0);
    check("mrst_cctrl", 64'(cctrl), 64'd0);
    check("mrst_cresult", cresult, 64'd0);
    sys_rst  = 1'b1;
    cend_cnt = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (cend) cend_cnt++;
    end
    check("mrst_no_cend", 64'(cend_cnt), 64'd0);
    word_val[0] = 64'h0000_0000_0000_0010;
    word_val[1] = 64'h0000_0000_0000_0300;
    word_val[2] = 64'h0000_0000_0004_0000;
    word_val[3] = 64'h5000_0000_0000_0000;
    run("restart", 2'd1, 64'h3000, 0, 1'b1, 0, 8'h21, 64'h5000_0000_0004_0310, 5, 4);

`ifdef CHECKER_TIMEOUT_EN
    run("timeout", 2'd1, 64'h5000, 0, 1'b0, 0, 8'h24, 64'd0, 17, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
